muldiv32: RTL and testbench
===========================

# muldiv32

Iterative 32-bit multiply/divide unit for the single-cycle CPU, producing the HI/LO register pair for MIPS `mult`, `multu`, `div` and `divu`.
- HI and LO feed the existing `mux2x32` that selects the `mfhi`/`mflo` write-back value.
- The control unit stalls the PC while `busy` is high.

## Interface
Parameters: none; fixed 32-bit datapath.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-high
- start  in  1  request a new operation; accepted only when `busy`=0
- op  in  2  00 `multu`, 01 `mult`, 10 `divu`, 11 `div`
- a  in  32  rs operand: multiplicand or dividend
- b  in  32  rt operand: multiplier or divisor
- hi_we  in  1  `mthi` write enable; honoured only when `busy`=0
- lo_we  in  1  `mtlo` write enable; honoured only when `busy`=0
- wdata  in  32  `mthi`/`mtlo` data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: HI/LO just updated by an operation
- dz  out  1  divide-by-zero flag; valid with `done`, held until the next accept
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `dz`=0, state IDLE.
- States and transitions:
  - IDLE -> RUN on `start`.
  - RUN -> FIX after 32 iterations.
  - FIX -> IDLE.
- Accept (IDLE, `start`=1):
  - latch |a|, |b|; for unsigned ops, absolute value = raw value
  - latch result sign and dividend sign
  - latch op; clear iteration counter; clear `dz`
- RUN, multiply: one shift-add step per cycle on a 64-bit accumulator.
- RUN, divide: one restoring shift-subtract step per cycle; quotient builds in the low half, remainder in the high half.
- FIX, multiply: negate the 64-bit product when the signs differ (signed op). HI = bits 63:32, LO = bits 31:0.
- FIX, divide:
  - LO = quotient, truncated toward zero.
  - HI = remainder; remainder sign follows the dividend.
  - Quotient is negated when the signs differ (signed op).
  - All arithmetic is mod 2^32.
- Divide by zero (`b`=0, either div op):
  - LO = 0xFFFFFFFF, HI = `a` unchanged.
  - `dz`=1.
  - Full latency is still taken.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, `dz`=0.
- HI/LO hold their old values throughout RUN. They change only in FIX or via `hi_we`/`lo_we`.
- `start` while `busy`=1: ignored, no queueing.
- `hi_we`/`lo_we` while `busy`=1: ignored.
- `hi_we`/`lo_we` together with an accepted `start`:
  - the write happens at that edge
  - the operation result later overwrites it
- `reset` mid-operation:
  - aborts at the next edge
  - all outputs return to reset values
  - no `done` is issued

## Timing
- Accept edge E0: `busy`=1 from E0.
- RUN: edges E1..E32.
- FIX: edge E33 writes HI/LO and `dz`, sets `done`=1, clears `busy`.
- Latency: `done` is high for exactly the one cycle following E33. New HI/LO are visible in that same cycle. `busy` is high for 33 cycles.
- Back-to-back: `start` in the `done` cycle is accepted, since `busy`=0.
- `mthi`/`mtlo`: HI/LO update at the edge where `hi_we`/`lo_we`=1, with no `done` pulse.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- `mult`, a=0xFFFFFFFD (-3), b=7:
  - `done` exactly 34 cycles after the `start` cycle
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB
  - `busy` high for 33 cycles
- `multu`, a=b=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001.
- `div`, a=0xFFFFFFF9 (-7), b=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- `div`, a=0x80000000, b=0xFFFFFFFF: LO=0x80000000, HI=0, `dz`=0.
- `divu`, a=100, b=0: LO=0xFFFFFFFF, HI=100, `dz`=1.
- `multu` 5×6 with a second `start` (`divu` 9/3) at cycle 5:
  - second start ignored; HI=0, LO=30
  - `start` in the `done` cycle is accepted
- `reset` at cycle 10 of a `multu`: the next cycle has `busy`=0 and HI=LO=0, and no `done` ever appears.
- `mthi` 0x1234 while idle: HI=0x1234 next cycle.
- `mthi` 0x1234 while busy: HI unchanged.

Source files
------------

// File: rtl/muldiv32.sv
// ============================================================================
//  Module      : muldiv32
//  Description : Iterative 32-bit multiply/divide unit producing MIPS HI/LO.
//                Shift-add multiply and restoring divide, one step per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] m_q, m_d;
    logic [31:0] araw_q, araw_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        negr_q, negr_d;
    logic        negm_q, negm_d;
    logic        bz_q, bz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;

    // op[0] selects signed, op[1] selects divide
    logic [31:0] abs_a, abs_b;
    assign abs_a = (op[0] && a[31]) ? (32'd0 - a) : a;
    assign abs_b = (op[0] && b[31]) ? (32'd0 - b) : b;

    // Multiply step: conditional add into the upper half, then shift right
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Divide step: shift left, trial-subtract the divisor from the 33-bit partial remainder
    logic [32:0] rem_sh;
    logic [33:0] rem_diff;
    logic [63:0] div_next;
    assign rem_sh   = {acc_q[63:32], acc_q[31]};
    assign rem_diff = {1'b0, rem_sh} - {2'b00, m_q};
    assign div_next = rem_diff[33] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                                   : {rem_diff[31:0], acc_q[30:0], 1'b1};

    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    assign prod_fix = negr_q ? (64'd0 - acc_q) : acc_q;
    assign quo_fix  = negr_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign rem_fix  = negm_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        m_d     = m_q;
        araw_d  = araw_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        negr_d  = negr_q;
        negm_d  = negm_q;
        bz_d    = bz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    state_d = S_RUN;
                    op_d    = op;
                    negr_d  = op[0] & (a[31] ^ b[31]);
                    negm_d  = op[0] & a[31];
                    bz_d    = op[1] & (b == 32'd0);
                    araw_d  = a;
                    cnt_d   = 5'd0;
                    dz_d    = 1'b0;
                    if (op[1]) begin
                        m_d   = abs_b;
                        acc_d = {32'd0, abs_a};
                    end else begin
                        m_d   = abs_a;
                        acc_d = {32'd0, abs_b};
                    end
                end
            end
            S_RUN: begin
                acc_d = op_q[1] ? div_next : mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    if (bz_q) begin
                        hi_d = araw_q;
                        lo_d = 32'hFFFF_FFFF;
                        dz_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= 64'd0;
            m_q     <= 32'd0;
            araw_q  <= 32'd0;
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            negr_q  <= 1'b0;
            negm_q  <= 1'b0;
            bz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            araw_q  <= araw_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            negr_q  <= negr_d;
            negm_q  <= negm_d;
            bz_q    <= bz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv32.sv
// ============================================================================
//  Module      : tb_muldiv32
//  Description : Scoreboard bench for muldiv32 with an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv32;

    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [64:0] exp_q[$];
    logic [64:0] mon_e;

    muldiv32 dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Returns {dz, hi, lo} from plain integer arithmetic
    function automatic logic [64:0] ref_model(input logic [1:0] f_op,
                                              input logic [31:0] fa,
                                              input logic [31:0] fb);
        longint      sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(fa));
        sb = longint'($signed(fb));
        case (f_op)
            2'b00: begin
                up = {32'd0, fa} * {32'd0, fb};
                return {1'b0, up};
            end
            2'b01: begin
                p = sa * sb;
                return {1'b0, p[63:0]};
            end
            2'b10: begin
                if (fb == 32'd0) return {1'b1, fa, 32'hFFFF_FFFF};
                return {1'b0, fa % fb, fa / fb};
            end
            default: begin
                if (fb == 32'd0) return {1'b1, fa, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: hi=%h lo=%h dz=%b with nothing pending", hi, lo, dz);
            end else begin
                mon_e = exp_q.pop_front();
                if ({dz, hi, lo} !== mon_e) begin
                    n_fail++;
                    $display("FAIL result: got dz=%b hi=%h lo=%h, expected dz=%b hi=%h lo=%h",
                             dz, hi, lo, mon_e[64], mon_e[63:32], mon_e[31:0]);
                end
            end
        end
    end

    // Must be entered just after a negedge; returns at the negedge where done is seen
    task automatic op_run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int inj_start, input int inj_mthi, input bit wr_lo);
        int          done_at;
        int          busy_cnt;
        bit          held;
        logic [31:0] hi0, lo0;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        exp_q.push_back(ref_model(o, x, y));
        if (wr_lo) begin
            lo_we = 1'b1;
            wdata = 32'hA5A5_5A5A;
        end
        done_at  = 0;
        busy_cnt = 0;
        held     = 1'b1;
        hi0      = '0;
        lo0      = '0;
        for (int i = 1; i <= 40 && done_at == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                lo_we = 1'b0;
                hi0   = hi;
                lo0   = lo;
                if (wr_lo) check("mtlo_with_start", {32'd0, lo}, 64'hA5A5_5A5A);
            end
            if (i == inj_start) begin
                start = 1'b1;
                op    = 2'b10;
                a     = 32'd9;
                b     = 32'd3;
            end
            if (i == inj_start + 1) start = 1'b0;
            if (i == inj_mthi) begin
                hi_we = 1'b1;
                wdata = 32'h0000_1234;
            end
            if (i == inj_mthi + 1) hi_we = 1'b0;
            if (busy) busy_cnt++;
            if (busy && i >= 2 && (hi !== hi0 || lo !== lo0)) held = 1'b0;
            if (done) done_at = i;
        end
        check("done_latency", 64'(done_at), 64'd34);
        check("busy_cycles", 64'(busy_cnt), 64'd33);
        check("hilo_hold_while_busy", {63'd0, held}, 64'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {29'd0, busy, done, dz, hi, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {29'd0, busy, done, dz, hi, lo}, 64'd0);

        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_idle", {32'd0, hi}, 64'h1234);
        lo_we = 1'b1;
        wdata = 32'h0000_5678;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_idle", {32'd0, lo}, 64'h5678);

        op_run(2'b01, 32'hFFFF_FFFD, 32'd7, 0, 0, 1'b0);
        check("mult_m3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        op_run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        op_run(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
        check("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        op_run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
        check("div_overflow", {31'd0, dz, hi, lo}, 64'h0000_0000_8000_0000);
        op_run(2'b10, 32'd100, 32'd0, 0, 0, 1'b0);
        check("divu_by_zero", {31'd0, dz, hi, lo}, {31'd0, 1'b1, 32'd100, 32'hFFFF_FFFF});
        repeat (2) @(negedge clk);
        check("dz_held", {63'd0, dz}, 64'd1);

        op_run(2'b00, 32'd5, 32'd6, 5, 8, 1'b1);
        check("multu_5x6_ignore_start", {hi, lo}, 64'd30);
        op_run(2'b10, 32'd9, 32'd3, 0, 0, 1'b0);
        check("back_to_back_divu", {31'd0, dz, hi, lo}, 64'd3);

        for (int k = 0; k < 24; k++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       r_b = 32'd0;
                1:       r_b = 32'($urandom_range(1, 15));
                2:       r_b = 32'hFFFF_FFFF;
                default: r_b = 32'($urandom);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op_run(r_op, r_a, r_b, 0, 0, 1'b0);
        end

        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd1234;
        b     = 32'd5678;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 10) reset = 1'b1;
        end
        @(negedge clk);
        check("reset_abort", {29'd0, busy, done, dz, hi, lo}, 64'd0);
        reset = 1'b0;
        repeat (45) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
